// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port synchronous RAM between fetch and load/store requesters.
// Define MEM_ARB_ROUND_ROBIN_EN for strict alternation instead of data priority with anti-starvation.
module unified_mem_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int READ_LAT     = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic          we_q, we_d, owner_q, owner_d, mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          grant, data_win;
  assign grant = (state_q == IDLE) & (if_req | d_req);
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  assign data_win = d_req & ~(if_req & last_q);
  assign last_d   = grant ? data_win : last_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) last_q <= 1'b0;
    else       last_q <= last_d;
`else
  logic [3:0] starve_q, starve_d;
  assign data_win = d_req & ~(if_req & (starve_q == 4'(STARVE_LIMIT)));
  // consecutive data grants while a fetch waits, saturating at the limit
  assign starve_d = !grant ? starve_q :
                    !(data_win & if_req) ? 4'd0 :
                    (starve_q == 4'(STARVE_LIMIT)) ? starve_q : starve_q + 4'd1;
  always_ff @(posedge clk or posedge reset)
    if (reset) starve_q <= 4'd0;
    else       starve_q <= starve_d;
`endif
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    case (state_q)
      IDLE: if (grant) begin
        state_d  = ISSUE;
        owner_d  = data_win;
        addr_d   = data_win ? d_addr : if_addr;
        wdata_d  = data_win ? d_wdata : wdata_q;
        we_d     = data_win & d_we;
        mem_en_d = 1'b1;
        mem_we_d = data_win & d_we;
      end
      ISSUE: begin
        state_d = we_q ? ACK : WAIT;
        cnt_d   = 2'(READ_LAT - 1);
      end
      WAIT: if (cnt_q == 2'd0) begin
        state_d    = ACK;
        if_rdata_d = owner_q ? if_rdata_q : mem_rdata;
        d_rdata_d  = owner_q ? mem_rdata : d_rdata_q;
      end else cnt_d = cnt_q - 2'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      owner_q    <= 1'b0;
      cnt_q      <= 2'd0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
    end
  assign if_ack    = (state_q == ACK) & ~owner_q;
  assign d_ack     = (state_q == ACK) & owner_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = state_q != IDLE;
  assign owner     = owner_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed vectors, contention/reset sequences and a random run against a transaction-level model.
module tb_unified_mem_arbiter;
  localparam int LA = 1;
  localparam int LB = 3;
  localparam int SL = 4;
  logic clk = 1'b0, reset_a = 1'b1, reset_b = 1'b1, ram_init = 1'b1;
  logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, b_if_req = 1'b0;
  logic [15:0] if_addr = '0, d_addr = '0, d_wdata = '0, b_if_addr = '0;
  logic if_ack, d_ack, a_mem_en, a_mem_we, busy, owner;
  logic [15:0] if_rdata, d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic b_if_ack, b_d_ack, b_mem_en, b_mem_we, b_busy, b_owner;
  logic [15:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [15:0] ram_a [0:255];
  logic [15:0] ram_b [0:255];
  logic [15:0] shadow [0:255];
  logic [15:0] pa;
  logic [15:0] pb [0:2];
  logic va = 1'b0;
  logic [2:0] vb = 3'b0;
  int total = 0, passed = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.READ_LAT(LA), .STARVE_LIMIT(SL)) ua (
    .clk(clk), .reset(reset_a), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .busy(busy), .owner(owner));

  unified_mem_arbiter #(.READ_LAT(LB), .STARVE_LIMIT(SL)) ub (
    .clk(clk), .reset(reset_b), .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0), .d_wdata(16'h0), .d_ack(b_d_ack), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy), .owner(b_owner));

  function automatic logic [15:0] pat(int i);
    return (i == 4) ? 16'hA5C3 : (16'(i * 257) ^ 16'h5A5A);
  endfunction

  // RAM models: read data is poisoned outside its one valid cycle
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) begin
        ram_a[i] <= pat(i);
        ram_b[i] <= pat(i);
      end
    end else begin
      if (a_mem_en && a_mem_we) ram_a[a_mem_addr[7:0]] <= a_mem_wdata;
      if (b_mem_en && b_mem_we) ram_b[b_mem_addr[7:0]] <= b_mem_wdata;
    end
    pa    <= ram_a[a_mem_addr[7:0]];
    va    <= a_mem_en && !a_mem_we;
    pb[0] <= ram_b[b_mem_addr[7:0]];
    pb[1] <= pb[0];
    pb[2] <= pb[1];
    vb    <= {vb[1:0], b_mem_en && !b_mem_we};
  end
  assign a_mem_rdata = va ? pa : 16'hDEAD;
  assign b_mem_rdata = vb[2] ? pb[2] : 16'hDEAD;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  typedef struct {
    logic        dp;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          ack_cyc;
  } vec_t;
  vec_t tv [7];

  task automatic run_vec(input vec_t v);
    bit done = 0;
    @(posedge clk); #1;
    if (v.dp) begin d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; end
    else begin if_req = 1; if_addr = v.addr; end
    for (int cyc = 0; cyc < 12 && !done; cyc++) begin
      @(negedge clk);
      if (cyc >= 1) begin
        chk("vec_mem_en", a_mem_en, cyc == 1);
        chk("vec_mem_we", a_mem_we, cyc == 1 && v.we);
      end
      if (cyc == 1) begin
        chk("vec_mem_addr", a_mem_addr, v.addr);
        chk("vec_owner", owner, v.dp);
        if (v.we) chk("vec_mem_wdata", a_mem_wdata, v.wdata);
      end
      if (v.dp ? d_ack : if_ack) begin
        done = 1;
        chk("vec_ack_cycle", cyc, v.ack_cyc);
        chk("vec_other_ack", v.dp ? if_ack : d_ack, 0);
        if (!v.we) chk("vec_rdata", v.dp ? d_rdata : if_rdata, v.rdata);
      end
    end
    chk("vec_ack_seen", done, 1);
    @(posedge clk); #1;
    if_req = 0; d_req = 0;
  endtask

  task automatic reset_a_pulse();
    @(posedge clk); #1;
    if_req = 0; d_req = 0; reset_a = 1;
    repeat (2) @(posedge clk);
    #1 reset_a = 0;
  endtask

  initial begin
    int k, pulses, c, nf, gc, ecyc, starve;
    bit ev, ep, erd, si, sd, dp, st, eia, eda, last_dp, done;
    logic [15:0] edat, m_if, m_d, a;
    tv[0] = '{1'b0, 1'b0, 16'h0004, 16'h0000, 16'hA5C3, 2 + LA};
    tv[1] = '{1'b1, 1'b1, 16'h0010, 16'h1234, 16'h0000, 2};
    tv[2] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h1234, 2 + LA};
    tv[3] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1234, 2 + LA};
    tv[4] = '{1'b1, 1'b1, 16'h0004, 16'hBEEF, 16'h0000, 2};
    tv[5] = '{1'b0, 1'b0, 16'h0004, 16'h0000, 16'hBEEF, 2 + LA};
    tv[6] = '{1'b1, 1'b0, 16'h0021, 16'h0000, 16'h7B7B, 2 + LA};

    @(posedge clk); #1 ram_init = 0;
    @(posedge clk); #1 reset_a = 0; reset_b = 0;
    @(negedge clk);
    chk("rst_a_ctrl", {if_ack, d_ack, a_mem_en, a_mem_we, busy, owner}, 0);
    chk("rst_a_addr", a_mem_addr, 0);
    chk("rst_a_wdata", a_mem_wdata, 0);
    chk("rst_a_rdata", {if_rdata, d_rdata}, 0);
    chk("rst_b_ctrl", {b_if_ack, b_d_ack, b_mem_en, b_mem_we, b_busy, b_owner}, 0);
    chk("rst_b_data", {b_mem_addr, b_mem_wdata}, 0);
    chk("rst_b_rdata", {b_if_rdata, b_d_rdata}, 0);

    for (int i = 0; i < 7; i++) run_vec(tv[i]);

    reset_a_pulse();
    @(posedge clk); #1;
    if_req = 1; if_addr = 16'h0008; d_req = 1; d_we = 1; d_addr = 16'h0040; d_wdata = 16'h5555;
    k = 0;
    for (int n = 0; n < 200 && k < 10; n++) begin
      @(negedge clk);
      if (a_mem_en) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        chk("grant_owner", owner, (k % 2) == 0);
`else
        chk("grant_owner", owner, (k % 5) != 4);
`endif
        k++;
      end
    end
    chk("grant_count", k, 10);
    reset_a_pulse();

    @(posedge clk); #1 b_if_req = 1; b_if_addr = 16'h0004;
    repeat (3) @(posedge clk);
    #1 chk("midop_b_busy", b_busy, 1);
    reset_b = 1; b_if_req = 0;
    #1 chk("midop_b_mem_en", b_mem_en, 0);
    chk("midop_b_state", b_busy, 0);
    pulses = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (b_if_ack) pulses++;
      if (n == 1) begin @(posedge clk); #1 reset_b = 0; end
    end
    chk("midop_no_ack", pulses, 0);
    @(posedge clk); #1 b_if_req = 1; b_if_addr = 16'h0020;
    done = 0;
    for (int cyc = 0; cyc < 12 && !done; cyc++) begin
      @(negedge clk);
      if (b_if_ack) begin
        done = 1;
        chk("post_rst_ack_cycle", cyc, 2 + LB);
        chk("post_rst_rdata", b_if_rdata, 16'h7A7A);
      end
    end
    chk("post_rst_ack_seen", done, 1);
    @(posedge clk); #1 b_if_req = 0;

    for (int i = 0; i < 256; i++) shadow[i] = ram_a[i];
    nf = 0; gc = -100; ecyc = 0; ev = 0; ep = 0; erd = 0; edat = 0;
    m_if = 0; m_d = 0; starve = 0; last_dp = 0; si = 0; sd = 0;
    for (c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (if_req && si) if_req = 0;
      if (!if_req && $urandom_range(2) == 0) begin if_req = 1; if_addr = 16'($urandom_range(31)); end
      if (d_req && sd) d_req = 0;
      if (!d_req && $urandom_range(2) == 0) begin
        d_req = 1; d_we = 1'($urandom_range(1)); d_addr = 16'($urandom_range(31)); d_wdata = 16'($urandom);
      end
      @(negedge clk);
      eia = ev && ecyc == c && !ep;
      eda = ev && ecyc == c && ep;
      chk("rnd_if_ack", if_ack, eia);
      chk("rnd_d_ack", d_ack, eda);
      if (eia) m_if = edat;
      if (eda && erd) m_d = edat;
      chk("rnd_if_rdata", if_rdata, m_if);
      chk("rnd_d_rdata", d_rdata, m_d);
      chk("rnd_busy", busy, c > gc && c < nf);
      if (c > gc && c < nf) chk("rnd_owner", owner, ep);
      if (c >= nf && (if_req || d_req)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        dp = d_req && !(if_req && last_dp);
        last_dp = dp;
`else
        dp = d_req && !(if_req && starve == SL);
        starve = !dp ? 0 : if_req ? (starve < SL ? starve + 1 : starve) : 0;
`endif
        a = dp ? d_addr : if_addr;
        st = dp && d_we;
        ev = 1; ep = dp; gc = c; erd = !st;
        if (st) begin shadow[a[7:0]] = d_wdata; ecyc = c + 2; nf = c + 3; end
        else begin edat = shadow[a[7:0]]; ecyc = c + 2 + LA; nf = c + 3 + LA; end
      end
      si = if_ack; sd = d_ack;
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
